// File: rtl/ysyx_210238_mem_arb_pkg.sv
// Shared definitions for the IF/LS memory-port arbiter: state encoding,
// memory size codes and the default starvation bound.
package ysyx_210238_mem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    BUSY_IF = 2'd1,
    BUSY_LS = 2'd2
  } arb_state_e;

  localparam logic [2:0] SIZE_B = 3'b000;
  localparam logic [2:0] SIZE_H = 3'b001;
  localparam logic [2:0] SIZE_W = 3'b010;
  localparam logic [2:0] SIZE_D = 3'b011;

  localparam int STARVE_MAX_DEFAULT = 4;

  // Width of a counter that must hold 0..max inclusive (at least one bit).
  function automatic int cnt_width(input int max_val);
    return (max_val < 1) ? 1 : $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/ysyx_210238_arb_sel.sv
// Two-way priority picker. LS normally wins a tie; after STARVE_MAX
// consecutive LS grants taken while IF was waiting, IF wins the next tie.
module ysyx_210238_arb_sel
  import ysyx_210238_mem_arb_pkg::*;
#(
  parameter int STARVE_MAX = STARVE_MAX_DEFAULT
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       if_valid,
  input  logic       ls_valid,
  input  logic       grant_en,
  output logic [1:0] grant      // one-hot {ls, if}
);

  localparam int CW = cnt_width(STARVE_MAX);
  localparam logic [CW-1:0] CNT_MAX = CW'(STARVE_MAX);

  logic [CW-1:0] cnt_q, cnt_d;
  logic          if_forced;

  // Pick the winner and compute the saturating starvation count.
  always_comb begin
    if_forced = (cnt_q == CNT_MAX);
    grant     = 2'b00;
    cnt_d     = cnt_q;
    if (grant_en) begin
      if (ls_valid && !(if_valid && if_forced)) begin
        grant = 2'b10;
      end else if (if_valid) begin
        grant = 2'b01;
      end
    end
    if (grant[1] && if_valid && !if_forced) begin
      cnt_d = cnt_q + 1'b1;
    end else if (grant[0]) begin
      cnt_d = '0;
    end
  end

  // Starvation counter register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/ysyx_210238_mem_arb.sv
// Shares the single memory port between instruction fetch (read-only) and
// load/store. The winning request is latched into registered o_mem_* fields
// and held until the memory's one-cycle ready pulse, which is routed back to
// the owner together with the unregistered read data.
module ysyx_210238_mem_arb
  import ysyx_210238_mem_arb_pkg::*;
#(
  parameter int AW         = 64,
  parameter int DW         = 64,
  parameter int STARVE_MAX = STARVE_MAX_DEFAULT
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            i_if_valid,
  input  logic [AW-1:0]   i_if_addr,
  input  logic [2:0]      i_if_size,
  output logic            o_if_ready,
  output logic [31:0]     o_if_rdata,
  input  logic            i_ls_valid,
  input  logic            i_ls_wen,
  input  logic [AW-1:0]   i_ls_addr,
  input  logic [2:0]      i_ls_size,
  input  logic [DW-1:0]   i_ls_wdata,
  input  logic [DW/8-1:0] i_ls_wmask,
  output logic            o_ls_ready,
  output logic [DW-1:0]   o_ls_rdata,
  output logic            o_mem_valid,
  output logic            o_mem_wen,
  output logic [AW-1:0]   o_mem_addr,
  output logic [2:0]      o_mem_size,
  output logic [DW-1:0]   o_mem_wdata,
  output logic [DW/8-1:0] o_mem_wmask,
  input  logic            i_mem_ready,
  input  logic [DW-1:0]   i_mem_rdata,
  output logic [1:0]      o_grant
);

  arb_state_e state_q, state_d;

  logic            valid_q, valid_d;
  logic            wen_q, wen_d;
  logic [AW-1:0]   addr_q, addr_d;
  logic [2:0]      size_q, size_d;
  logic [DW-1:0]   wdata_q, wdata_d;
  logic [DW/8-1:0] wmask_q, wmask_d;
  logic [1:0]      grant;

  ysyx_210238_arb_sel #(
    .STARVE_MAX(STARVE_MAX)
  ) u_sel (
    .clk      (clk),
    .rst_n    (rst_n),
    .if_valid (i_if_valid),
    .ls_valid (i_ls_valid),
    .grant_en (state_q == IDLE),
    .grant    (grant)
  );

  // Next-state logic: latch the winner in IDLE, hold fields until ready.
  always_comb begin
    state_d = state_q;
    valid_d = valid_q;
    wen_d   = wen_q;
    addr_d  = addr_q;
    size_d  = size_q;
    wdata_d = wdata_q;
    wmask_d = wmask_q;
    unique case (state_q)
      IDLE: begin
        if (grant[1]) begin
          state_d = BUSY_LS;
          valid_d = 1'b1;
          wen_d   = i_ls_wen;
          addr_d  = i_ls_addr;
          size_d  = i_ls_size;
          wdata_d = i_ls_wdata;
          wmask_d = i_ls_wmask;
        end else if (grant[0]) begin
          state_d = BUSY_IF;
          valid_d = 1'b1;
          wen_d   = 1'b0;
          addr_d  = i_if_addr;
          size_d  = i_if_size;
          wdata_d = '0;
          wmask_d = '0;
        end
      end
      BUSY_IF, BUSY_LS: begin
        if (i_mem_ready) begin
          state_d = IDLE;
          valid_d = 1'b0;
        end
      end
      default: begin
        state_d = IDLE;
        valid_d = 1'b0;
      end
    endcase
  end

  // State and memory-request registers; reset drops the request at once.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      valid_q <= 1'b0;
      wen_q   <= 1'b0;
      addr_q  <= '0;
      size_q  <= '0;
      wdata_q <= '0;
      wmask_q <= '0;
    end else begin
      state_q <= state_d;
      valid_q <= valid_d;
      wen_q   <= wen_d;
      addr_q  <= addr_d;
      size_q  <= size_d;
      wdata_q <= wdata_d;
      wmask_q <= wmask_d;
    end
  end

  assign o_mem_valid = valid_q;
  assign o_mem_wen   = wen_q;
  assign o_mem_addr  = addr_q;
  assign o_mem_size  = size_q;
  assign o_mem_wdata = wdata_q;
  assign o_mem_wmask = wmask_q;

  // Ready is steered to the owner combinationally; states are exclusive,
  // so the two readys can never coincide. A ready seen in IDLE goes nowhere.
  assign o_if_ready = i_mem_ready & (state_q == BUSY_IF);
  assign o_ls_ready = i_mem_ready & (state_q == BUSY_LS);
  assign o_if_rdata = i_mem_rdata[31:0];
  assign o_ls_rdata = i_mem_rdata;
  assign o_grant    = {state_q == BUSY_LS, state_q == BUSY_IF};

endmodule

// File: doc/ysyx_210238_mem_arb.md
Name: ysyx_210238_mem_arb

Overview:
Two-requester arbiter sharing the single core memory port between the instruction fetch unit (read-only) and the load/store unit (read/write). It latches the winning request, drives it onto the memory port with a valid/ready handshake, and routes the ready pulse and read data back to the winner. The load/store unit has priority, and a bounded starvation counter guarantees forward progress for fetch.

Parameters:
AW, 64, address width
DW, 64, memory data width
STARVE_MAX, 4, consecutive LS grants allowed while IF waits before IF is forced

Ports:
clk  input  1  clock
rst_n  input  1  reset, asynchronous, active-low
i_if_valid  input  1  IF read request
i_if_addr  input  AW  IF address
i_if_size  input  3  IF size code
o_if_ready  output  1  IF transaction done; o_if_rdata valid this cycle
o_if_rdata  output  32  i_mem_rdata[31:0]
i_ls_valid  input  1  LS request
i_ls_wen  input  1  1 = store
i_ls_addr  input  AW  LS address
i_ls_size  input  3  LS size code
i_ls_wdata  input  DW  store data
i_ls_wmask  input  DW/8  byte mask
o_ls_ready  output  1  LS transaction done
o_ls_rdata  output  DW  i_mem_rdata passthrough
o_mem_valid  output  1  memory request valid (registered)
o_mem_wen  output  1  registered
o_mem_addr  output  AW  registered
o_mem_size  output  3  registered
o_mem_wdata  output  DW  registered
o_mem_wmask  output  DW/8  registered
i_mem_ready  input  1  one-cycle done pulse; i_mem_rdata valid with it
i_mem_rdata  input  DW  read data
o_grant  output  2  {ls,if} owner of current transaction (debug)

Behaviour:
- Reset (asynchronous, active-low): state IDLE, starvation counter 0, every o_mem_* 0, o_grant 0. o_if_ready and o_ls_ready are 0 because they are gated by state. Reset mid-transaction drops o_mem_valid immediately, without waiting for a clock edge. Any i_mem_ready that arrives after reset is ignored.
- States: IDLE, BUSY_IF, BUSY_LS.
- IDLE: requests are sampled on each edge.
  - If neither valid: stay in IDLE.
  - Otherwise pick a winner, latch its fields into the o_mem_* registers, set o_mem_valid to 1, and go to BUSY_IF or BUSY_LS.
  - Latency: request seen at edge N, so o_mem_valid = 1 during cycle N+1.
- Selection:
  - Only one valid: that requester wins.
  - Both valid: LS wins unless counter == STARVE_MAX, in which case IF wins.
- Counter:
  - Increments, saturating at STARVE_MAX, when LS is granted while i_if_valid = 1.
  - Clears when IF is granted.
  - Otherwise holds.
- IF grant: o_mem_wen = 0, o_mem_wmask = 0, o_mem_wdata = 0.
- BUSY_x:
  - All o_mem_* registers are held stable until i_mem_ready.
  - i_mem_ready may arrive in the same cycle o_mem_valid first rises (zero wait).
  - On an edge with i_mem_ready = 1: o_mem_valid goes to 0 and state returns to IDLE.
  - The next grant can therefore start at the following IDLE edge: minimum spacing is 2 cycles per transaction.
- Ready routing is combinational:
  - o_if_ready = i_mem_ready & (state == BUSY_IF).
  - o_ls_ready = i_mem_ready & (state == BUSY_LS).
  - o_if_ready and o_ls_ready are never high in the same cycle.
- Rdata is passthrough and unregistered; it is meaningful only while the corresponding ready is high.
- Requester contract: hold valid and all fields stable until its ready pulse.
  - Fields are sampled only in IDLE, so changes made during BUSY have no effect.
  - If a requester drops valid mid-transaction, the memory transaction still completes and the ready pulse is still emitted; the requester discards it.
- i_mem_ready while in IDLE: ignored, no ready output, no state change.
- Size codes pass through unmodified. There is no alignment check and no address translation.

Decomposition:
- Shared package holds:
  - state encodings IDLE = 2'd0, BUSY_IF = 2'd1, BUSY_LS = 2'd2;
  - size codes SIZE_B = 3'b000, SIZE_H = 3'b001, SIZE_W = 3'b010, SIZE_D = 3'b011;
  - default STARVE_MAX.
- One sub-module: ysyx_210238_arb_sel, the two-way priority picker plus saturating starvation counter.
  - Inputs: if_valid, ls_valid, grant_en (state == IDLE).
  - Output: one-hot grant.

Test Plan:
- Lone IF read, addr 0x8000_0000, size 3'b010; memory asserts ready 3 cycles after o_mem_valid with rdata 0x0000_0013 -> o_mem_valid rises 1 cycle after request; o_mem_addr = 0x8000_0000, wen = 0; o_if_ready is a single-cycle pulse with o_if_rdata = 0x13; state returns to IDLE.
- IF read 0x8000_0004 and LS store (addr 0x8000_1000, wdata 0xDEADBEEF, wmask 0x0F) valid on the same edge -> LS issued first with wen = 1 and wmask 0x0F; IF issued on the IDLE edge after o_ls_ready; the two readys never overlap.
- LS valid continuously, IF valid continuously, zero-wait memory -> grant sequence LS, LS, LS, LS, IF, LS...; counter returns to 0 after the IF grant.
- Zero-wait memory (i_mem_ready tied to o_mem_valid), IF only -> a transaction every 2 cycles; addresses match each request; o_if_ready pulses once per transaction.
- rst_n pulled low between clock edges while o_mem_valid = 1 -> o_mem_valid = 0 before the next edge; after release, an i_mem_ready pulse gives o_if_ready = o_ls_ready = 0.
- i_mem_ready pulse while IDLE with no requests -> no ready outputs, o_mem_valid stays 0, o_grant = 0.
